// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between vga_timing_gen (master) and the pixel/colour stage (slave).
// TESTPAT_RGB is present only when VGA_TESTPAT_EN is defined.
interface vga_timing_gen_if;
  logic       en;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_TESTPAT_EN
  logic [7:0] testpat_rgb;
`endif

`ifdef VGA_TESTPAT_EN
  modport master (
    input  en,
    output pix_en, hsync, vsync, active, x, y, line_start, frame_start, testpat_rgb
  );
  modport slave (
    output en,
    input  pix_en, hsync, vsync, active, x, y, line_start, frame_start, testpat_rgb
  );
`else
  modport master (
    input  en,
    output pix_en, hsync, vsync, active, x, y, line_start, frame_start
  );
  modport slave (
    output en,
    input  pix_en, hsync, vsync, active, x, y, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, sync/active/coordinate outputs.
// Optional border test pattern on TESTPAT_RGB when VGA_TESTPAT_EN is defined.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(CLK_DIV - 1);

  localparam logic [9:0] H_ACT_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FRONT_LAST = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FRONT_LAST = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCS, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} v_state_t;

  logic [DC_W-1:0] dc_q, dc_d;
  logic [9:0]      hc_q, hc_d;
  logic [9:0]      vc_q, vc_d;
  h_state_t        h_state_q, h_state_d;
  v_state_t        v_state_q, v_state_d;

  logic            pix_en_q, pix_en_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            active_q, active_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
`ifdef VGA_TESTPAT_EN
  logic [7:0]      rgb_q, rgb_d;
  logic            border;
`endif

  logic            strobe;
  logic            line_wrap;
  logic            pix_active;

  always_comb begin
    strobe     = vga.en && (dc_q == DC_LAST);
    line_wrap  = strobe && (hc_q == H_LAST);
    pix_active = (h_state_q == H_ACT) && (v_state_q == V_ACT);
  end

  always_comb begin
    dc_d = dc_q;
    hc_d = hc_q;
    vc_d = vc_q;
    if (vga.en) begin
      dc_d = strobe ? '0 : dc_q + 1'b1;
    end
    if (strobe) begin
      hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    end
    if (line_wrap) begin
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
    end
  end

  // State tracks the region of the current counter value; it moves on the strobe that leaves a region.
  always_comb begin
    h_state_d = h_state_q;
    if (strobe) begin
      case (h_state_q)
        H_ACT:   if (hc_q == H_ACT_LAST)   h_state_d = H_FRONT;
        H_FRONT: if (hc_q == H_FRONT_LAST) h_state_d = H_SYNCS;
        H_SYNCS: if (hc_q == H_SYNC_LAST)  h_state_d = H_BACK;
        H_BACK:  if (hc_q == H_LAST)       h_state_d = H_ACT;
        default: h_state_d = H_ACT;
      endcase
    end
  end

  always_comb begin
    v_state_d = v_state_q;
    if (line_wrap) begin
      case (v_state_q)
        V_ACT:   if (vc_q == V_ACT_LAST)   v_state_d = V_FRONT;
        V_FRONT: if (vc_q == V_FRONT_LAST) v_state_d = V_SYNCS;
        V_SYNCS: if (vc_q == V_SYNC_LAST)  v_state_d = V_BACK;
        V_BACK:  if (vc_q == V_LAST)       v_state_d = V_ACT;
        default: v_state_d = V_ACT;
      endcase
    end
  end

`ifdef VGA_TESTPAT_EN
  always_comb begin
    border = (hc_q == 10'd0) || (hc_q == H_ACT_LAST) ||
             (vc_q == 10'd0) || (vc_q == V_ACT_LAST);
    rgb_d  = rgb_q;
    if (strobe) begin
      rgb_d = (pix_active && border) ? 8'h1C : 8'h00;
    end
  end
`endif

  // Level outputs hold between strobes; pulses are cleared on every non-strobe cycle.
  always_comb begin
    pix_en_d      = strobe;
    line_start_d  = strobe && (hc_q == 10'd0);
    frame_start_d = strobe && (hc_q == 10'd0) && (vc_q == 10'd0);
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    x_d           = x_q;
    y_d           = y_q;
    if (strobe) begin
      hsync_d  = (h_state_q == H_SYNCS) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = (v_state_q == V_SYNCS) ? SYNC_POL : ~SYNC_POL;
      active_d = pix_active;
      x_d      = hc_q;
      y_d      = vc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dc_q          <= '0;
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      h_state_q     <= H_ACT;
      v_state_q     <= V_ACT;
      pix_en_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TESTPAT_EN
      rgb_q         <= 8'h00;
`endif
    end else begin
      dc_q          <= dc_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      pix_en_q      <= pix_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TESTPAT_EN
      rgb_q         <= rgb_d;
`endif
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.active      = active_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
`ifdef VGA_TESTPAT_EN
  assign vga.testpat_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, checked against an arithmetic
// pixel-index model; test-pattern checks compile in when VGA_TESTPAT_EN is defined.
module tb_vga_timing_gen;

  localparam int DIV = 2;
  localparam int HA  = 16;
  localparam int HF  = 3;
  localparam int HS  = 4;
  localparam int HB  = 5;
  localparam int VA  = 10;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam bit POL = 1'b0;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;

  logic clk;
  logic reset;
  logic en;

  int check_count;
  int error_count;

  longint en_cycles;
  longint pix_idx;
  int     hm;
  int     vm;
  int     exp_pix;
  int     exp_hsync;
  int     exp_vsync;
  int     exp_active;
  int     exp_x;
  int     exp_y;
  int     exp_ls;
  int     exp_fs;
  int     exp_rgb;

  vga_timing_gen_if vga_bus ();

  assign vga_bus.en = en;

  vga_timing_gen #(
    .CLK_DIV  (DIV),
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_POL (POL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the n-th enabled cycle (counting from 0) strobes when n mod DIV == DIV-1,
  // and that strobe shows pixel number n/DIV of an endless raster scan.
  always @(posedge clk) begin
    if (reset) begin
      en_cycles  = 0;
      exp_pix    = 0;
      exp_hsync  = ~POL;
      exp_vsync  = ~POL;
      exp_active = 0;
      exp_x      = 0;
      exp_y      = 0;
      exp_ls     = 0;
      exp_fs     = 0;
      exp_rgb    = 0;
    end else if (en) begin
      if (en_cycles % DIV == DIV - 1) begin
        pix_idx    = en_cycles / DIV;
        hm         = int'(pix_idx % HT);
        vm         = int'((pix_idx / HT) % VT);
        exp_pix    = 1;
        exp_x      = hm;
        exp_y      = vm;
        exp_hsync  = (hm >= HA + HF && hm < HA + HF + HS) ? POL : ~POL;
        exp_vsync  = (vm >= VA + VF && vm < VA + VF + VS) ? POL : ~POL;
        exp_active = (hm < HA && vm < VA) ? 1 : 0;
        exp_ls     = (hm == 0) ? 1 : 0;
        exp_fs     = (hm == 0 && vm == 0) ? 1 : 0;
        exp_rgb    = (exp_active == 1 &&
                      (hm == 0 || hm == HA - 1 || vm == 0 || vm == VA - 1)) ? 'h1C : 'h00;
      end else begin
        exp_pix = 0;
        exp_ls  = 0;
        exp_fs  = 0;
      end
      en_cycles = en_cycles + 1;
    end else begin
      exp_pix = 0;
      exp_ls  = 0;
      exp_fs  = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("pix_en", 32'(vga_bus.pix_en), 32'(exp_pix));
    checkOutput("hsync", 32'(vga_bus.hsync), 32'(exp_hsync & 1));
    checkOutput("vsync", 32'(vga_bus.vsync), 32'(exp_vsync & 1));
    checkOutput("active", 32'(vga_bus.active), 32'(exp_active));
    checkOutput("x", 32'(vga_bus.x), 32'(exp_x));
    checkOutput("y", 32'(vga_bus.y), 32'(exp_y));
    checkOutput("line_start", 32'(vga_bus.line_start), 32'(exp_ls));
    checkOutput("frame_start", 32'(vga_bus.frame_start), 32'(exp_fs));
`ifdef VGA_TESTPAT_EN
    checkOutput("testpat_rgb", 32'(vga_bus.testpat_rgb), 32'(exp_rgb));
`endif
  endtask

  // Mostly enabled with short random pauses, and a rare mid-frame reset.
  task automatic applyStimulus();
    reset = ($urandom_range(0, 1499) == 0);
    en    = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    reset = 1'b1;
    en    = 1'b1;

    @(negedge clk);
    checkOutput("rst_x", 32'(vga_bus.x), 32'd0);
    checkOutput("rst_y", 32'(vga_bus.y), 32'd0);
    checkOutput("rst_hsync", 32'(vga_bus.hsync), 32'd1);
    checkOutput("rst_vsync", 32'(vga_bus.vsync), 32'd1);
    checkOutput("rst_active", 32'(vga_bus.active), 32'd0);
    checkOutput("rst_pix_en", 32'(vga_bus.pix_en), 32'd0);
    checkOutput("rst_frame_start", 32'(vga_bus.frame_start), 32'd0);
    compareModel();
    reset = 1'b0;

    @(negedge clk);
    checkOutput("first_gap_pix_en", 32'(vga_bus.pix_en), 32'd0);
    compareModel();

    @(negedge clk);
    checkOutput("first_pix_en", 32'(vga_bus.pix_en), 32'd1);
    checkOutput("first_frame_start", 32'(vga_bus.frame_start), 32'd1);
    checkOutput("first_active", 32'(vga_bus.active), 32'd1);
    checkOutput("first_x", 32'(vga_bus.x), 32'd0);
    compareModel();

    for (int i = 0; i < 9000; i++) begin
      applyStimulus();
      @(negedge clk);
      compareModel();
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
